// File: rtl/program_counter.sv
// Program counter for the SelfMadeCPU fetch path: BOOT/RUN/HALT control with increment or jump.
// Optional call/return with a single return register is enabled by defining PC_CALL_EN.
module program_counter #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_jmp,
    input  logic [ADDR_W-1:0] i_jmp_addr,
    input  logic              i_halt,
    input  logic              i_resume,
`ifdef PC_CALL_EN
    input  logic              i_call,
    input  logic              i_ret,
`endif
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_jmp_sel,
    output logic              o_valid,
    output logic              o_halted,
    output logic              o_wrap
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              wrap_q, wrap_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              redirect;

    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef PC_CALL_EN
    logic [ADDR_W-1:0] ret_q, ret_d;

    assign redirect = i_jmp | i_call | i_ret;

    // Return takes precedence over call/jump when selecting the next address.
    always_comb begin
        o_next_pc = pc_inc;
        if (i_ret) begin
            o_next_pc = ret_q;
        end else if (i_call || i_jmp) begin
            o_next_pc = i_jmp_addr;
        end
    end
`else
    assign redirect = i_jmp;

    always_comb begin
        o_next_pc = pc_inc;
        if (i_jmp) begin
            o_next_pc = i_jmp_addr;
        end
    end
`endif

    assign o_jmp_sel = (state_q == S_RUN) && redirect;

    // Next-state and next-output decision.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap_d  = 1'b0;
`ifdef PC_CALL_EN
        ret_d   = ret_q;
`endif
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (i_halt) begin
                    state_d = S_HALT;
                end else if (i_en) begin
                    pc_d = o_next_pc;
                    // Only a sequential increment can wrap; jumps never flag it.
                    if (!redirect && (&pc_q)) begin
                        wrap_d = 1'b1;
                    end
`ifdef PC_CALL_EN
                    if (i_call && !i_ret) begin
                        ret_d = pc_inc;
                    end
`endif
                end
            end
            S_HALT: begin
                if (i_resume) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
        valid_d  = (state_d == S_RUN);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_BOOT;
            pc_q     <= ADDR_W'(RESET_ADDR);
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            wrap_q   <= 1'b0;
`ifdef PC_CALL_EN
            ret_q    <= ADDR_W'(RESET_ADDR);
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            wrap_q   <= wrap_d;
`ifdef PC_CALL_EN
            ret_q    <= ret_d;
`endif
        end
    end

    assign o_pc     = pc_q;
    assign o_valid  = valid_q;
    assign o_halted = halted_q;
    assign o_wrap   = wrap_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (ADDR_W=4, RESET_ADDR=0).
module tb_program_counter;

    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_en;
    logic              i_jmp;
    logic [ADDR_W-1:0] i_jmp_addr;
    logic              i_halt;
    logic              i_resume;
`ifdef PC_CALL_EN
    logic              i_call;
    logic              i_ret;
`endif
    logic [ADDR_W-1:0] o_pc;
    logic [ADDR_W-1:0] o_next_pc;
    logic              o_jmp_sel;
    logic              o_valid;
    logic              o_halted;
    logic              o_wrap;

    int tests = 0;
    int fails = 0;

    program_counter #(.ADDR_W(ADDR_W), .RESET_ADDR(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_jmp      (i_jmp),
        .i_jmp_addr (i_jmp_addr),
        .i_halt     (i_halt),
        .i_resume   (i_resume),
`ifdef PC_CALL_EN
        .i_call     (i_call),
        .i_ret      (i_ret),
`endif
        .o_pc       (o_pc),
        .o_next_pc  (o_next_pc),
        .o_jmp_sel  (o_jmp_sel),
        .o_valid    (o_valid),
        .o_halted   (o_halted),
        .o_wrap     (o_wrap)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_en = 1'b0; i_jmp = 1'b0; i_jmp_addr = '0; i_halt = 1'b0; i_resume = 1'b0;
`ifdef PC_CALL_EN
        i_call = 1'b0; i_ret = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #2;
        tests++; if (o_pc !== 4'd0) begin fails++; $display("FAIL reset_pc got=%0d exp=0", o_pc); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        tests++; if (o_halted !== 1'b0) begin fails++; $display("FAIL reset_halted got=%b exp=0", o_halted); end
        tests++; if (o_wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got=%b exp=0", o_wrap); end
        step();
        step();
        rst = 1'b0;
        i_en = 1'b1;
        #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL boot_valid got=%b exp=0", o_valid); end
        step();
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL run_valid got=%b exp=1", o_valid); end
        tests++; if (o_pc !== 4'd0) begin fails++; $display("FAIL boot_ignores_en got=%0d exp=0", o_pc); end
        for (int k = 1; k <= 3; k++) begin
            step();
            tests++; if (o_pc !== 4'(k)) begin fails++; $display("FAIL incr_seq got=%0d exp=%0d", o_pc, k); end
        end
    endtask

    task automatic test_jump();
        i_en = 1'b1; i_jmp = 1'b1; i_jmp_addr = 4'd9;
        #1;
        tests++; if (o_next_pc !== 4'd9) begin fails++; $display("FAIL jump_next_pc got=%0d exp=9", o_next_pc); end
        tests++; if (o_jmp_sel !== 1'b1) begin fails++; $display("FAIL jump_sel got=%b exp=1", o_jmp_sel); end
        step();
        tests++; if (o_pc !== 4'd9) begin fails++; $display("FAIL jump_pc got=%0d exp=9", o_pc); end
        i_jmp = 1'b0;
        #1;
        tests++; if (o_next_pc !== 4'd10) begin fails++; $display("FAIL seq_next_pc got=%0d exp=10", o_next_pc); end
        tests++; if (o_jmp_sel !== 1'b0) begin fails++; $display("FAIL seq_sel got=%b exp=0", o_jmp_sel); end
    endtask

    task automatic test_wrap();
        i_en = 1'b1; i_jmp = 1'b1; i_jmp_addr = 4'd15;
        step();
        tests++; if (o_pc !== 4'd15) begin fails++; $display("FAIL wrap_setup got=%0d exp=15", o_pc); end
        tests++; if (o_wrap !== 1'b0) begin fails++; $display("FAIL wrap_on_jump got=%b exp=0", o_wrap); end
        i_jmp = 1'b0;
        #1;
        tests++; if (o_next_pc !== 4'd0) begin fails++; $display("FAIL wrap_next_pc got=%0d exp=0", o_next_pc); end
        step();
        tests++; if (o_pc !== 4'd0) begin fails++; $display("FAIL wrap_pc got=%0d exp=0", o_pc); end
        tests++; if (o_wrap !== 1'b1) begin fails++; $display("FAIL wrap_pulse got=%b exp=1", o_wrap); end
        step();
        tests++; if (o_pc !== 4'd1) begin fails++; $display("FAIL after_wrap_pc got=%0d exp=1", o_pc); end
        tests++; if (o_wrap !== 1'b0) begin fails++; $display("FAIL wrap_one_cycle got=%b exp=0", o_wrap); end
        i_jmp = 1'b1; i_jmp_addr = 4'd15;
        step();
        i_jmp_addr = 4'd0;
        step();
        tests++; if (o_pc !== 4'd0) begin fails++; $display("FAIL jump_15_to_0 got=%0d exp=0", o_pc); end
        tests++; if (o_wrap !== 1'b0) begin fails++; $display("FAIL jump_no_wrap got=%b exp=0", o_wrap); end
        i_jmp = 1'b0;
    endtask

    task automatic test_halt_resume();
        i_en = 1'b1; i_jmp = 1'b1; i_jmp_addr = 4'd5;
        step();
        tests++; if (o_pc !== 4'd5) begin fails++; $display("FAIL halt_setup got=%0d exp=5", o_pc); end
        i_halt = 1'b1; i_jmp_addr = 4'd12;
        step();
        tests++; if (o_pc !== 4'd5) begin fails++; $display("FAIL halt_holds_pc got=%0d exp=5", o_pc); end
        tests++; if (o_halted !== 1'b1) begin fails++; $display("FAIL halted got=%b exp=1", o_halted); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL halt_valid got=%b exp=0", o_valid); end
        i_halt = 1'b0;
        #1;
        tests++; if (o_jmp_sel !== 1'b0) begin fails++; $display("FAIL halt_jmp_sel got=%b exp=0", o_jmp_sel); end
        step();
        tests++; if (o_pc !== 4'd5) begin fails++; $display("FAIL halt_ignores_jmp got=%0d exp=5", o_pc); end
        tests++; if (o_halted !== 1'b1) begin fails++; $display("FAIL halt_stays got=%b exp=1", o_halted); end
        i_jmp = 1'b0; i_halt = 1'b1; i_resume = 1'b1;
        step();
        tests++; if (o_halted !== 1'b0) begin fails++; $display("FAIL resume_halted got=%b exp=0", o_halted); end
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL resume_valid got=%b exp=1", o_valid); end
        tests++; if (o_pc !== 4'd5) begin fails++; $display("FAIL resume_no_advance got=%0d exp=5", o_pc); end
        i_halt = 1'b0; i_resume = 1'b0;
        step();
        tests++; if (o_pc !== 4'd6) begin fails++; $display("FAIL post_resume_incr got=%0d exp=6", o_pc); end
    endtask

    task automatic test_hold();
        i_en = 1'b0;
        step();
        tests++; if (o_pc !== 4'd6) begin fails++; $display("FAIL hold_pc got=%0d exp=6", o_pc); end
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL hold_valid got=%b exp=1", o_valid); end
    endtask

    task automatic test_async_reset();
        i_en = 1'b1;
        step();
        tests++; if (o_pc !== 4'd7) begin fails++; $display("FAIL areset_setup got=%0d exp=7", o_pc); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (o_pc !== 4'd0) begin fails++; $display("FAIL areset_pc got=%0d exp=0", o_pc); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL areset_valid got=%b exp=0", o_valid); end
        step();
        rst = 1'b0;
        step();
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL areset_boot_run got=%b exp=1", o_valid); end
        tests++; if (o_pc !== 4'd0) begin fails++; $display("FAIL areset_boot_pc got=%0d exp=0", o_pc); end
    endtask

`ifdef PC_CALL_EN
    task automatic test_call_ret();
        idle_inputs();
        i_en = 1'b1;
        step();
        step();
        tests++; if (o_pc !== 4'd2) begin fails++; $display("FAIL call_setup got=%0d exp=2", o_pc); end
        i_call = 1'b1; i_jmp_addr = 4'd10;
        #1;
        tests++; if (o_jmp_sel !== 1'b1) begin fails++; $display("FAIL call_sel got=%b exp=1", o_jmp_sel); end
        tests++; if (o_next_pc !== 4'd10) begin fails++; $display("FAIL call_next_pc got=%0d exp=10", o_next_pc); end
        step();
        tests++; if (o_pc !== 4'd10) begin fails++; $display("FAIL call_pc got=%0d exp=10", o_pc); end
        i_call = 1'b0;
        step();
        tests++; if (o_pc !== 4'd11) begin fails++; $display("FAIL call_advance got=%0d exp=11", o_pc); end
        i_ret = 1'b1;
        #1;
        tests++; if (o_next_pc !== 4'd3) begin fails++; $display("FAIL ret_next_pc got=%0d exp=3", o_next_pc); end
        tests++; if (o_jmp_sel !== 1'b1) begin fails++; $display("FAIL ret_sel got=%b exp=1", o_jmp_sel); end
        step();
        tests++; if (o_pc !== 4'd3) begin fails++; $display("FAIL ret_pc got=%0d exp=3", o_pc); end
        i_ret = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_jump();
        test_wrap();
        test_halt_resume();
        test_hold();
        test_async_reset();
`ifdef PC_CALL_EN
        test_call_ret();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_counter.md
# program_counter

Program-counter stage for the SelfMadeCPU datapath. Holds the current instruction address and computes the next address on every enabled cycle, choosing between sequential increment and a jump target. Sits directly upstream of the 2:1 next-address select and instruction fetch. `o_pc` drives the fetch address; `o_next_pc` and `o_jmp_sel` feed the select stage.

## Interface
- `ADDR_W`, default 4: address width in bits.
- `RESET_ADDR`, default 0: address loaded on reset. Must fit in `ADDR_W`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `i_en`, in, 1: advance strobe; the PC updates only in RUN with `i_en`=1.
- `i_jmp`, in, 1: take jump this cycle.
- `i_jmp_addr`, in, ADDR_W: jump target.
- `i_halt`, in, 1: request halt.
- `i_resume`, in, 1: leave HALT.
- `o_pc`, out, ADDR_W: current address, registered.
- `o_next_pc`, out, ADDR_W: combinational next address, `i_jmp ? i_jmp_addr : o_pc+1` (modulo 2^ADDR_W).
- `o_jmp_sel`, out, 1: combinational copy of `i_jmp` gated by the RUN state; this is the select for the downstream mux.
- `o_valid`, out, 1: `o_pc` is a fetchable address this cycle (registered).
- `o_halted`, out, 1: state is HALT (registered).
- `o_wrap`, out, 1: one-cycle registered pulse when an increment wraps from 2^ADDR_W−1 to 0.

## Operation
- States: BOOT, RUN, HALT. Encoding is free.
- Reset values, applied while `rst`=1 regardless of `clk`:
  - state=BOOT, `o_pc`=RESET_ADDR, `o_valid`=0, `o_halted`=0, `o_wrap`=0.
  - Return register (see Configuration) = RESET_ADDR.
- BOOT: lasts exactly one clock after `rst` falls, then goes to RUN unconditionally. Inputs are ignored in BOOT.
- RUN, priority highest first:
  1. `i_halt`=1: go to HALT. `o_pc` is held, even if `i_jmp` or `i_en` is also set.
  2. `i_en`=1 and `i_jmp`=1: `o_pc` ← `i_jmp_addr`.
  3. `i_en`=1: `o_pc` ← `o_pc`+1. Pulse `o_wrap` if the old `o_pc` was all-ones.
  4. Otherwise hold.
- A jump never asserts `o_wrap`, including a jump from all-ones to 0.
- HALT:
  - `o_pc` is held. `i_jmp` and `i_en` are ignored and `o_jmp_sel`=0.
  - `i_resume`=1: go to RUN on the next edge. The PC does not advance on that edge.
  - `i_halt` and `i_resume` both set in HALT: resume wins.
- `o_valid`=1 in RUN, 0 in BOOT and HALT.
- Arithmetic is unsigned, ADDR_W bits, with silent modulo wrap. No carry output other than `o_wrap`.
- Asserting `rst` mid-operation aborts immediately to the reset values. Nothing in flight survives.

## Timing
- A decision made at edge N is visible on `o_pc` after edge N. Latency from `i_en` to the new `o_pc` is 1 cycle.
- `o_next_pc` and `o_jmp_sel` are combinational from `o_pc` and `i_jmp`, with zero latency. The downstream stage samples them in the same cycle.
- `o_wrap` is high for exactly the one cycle following the wrapping edge.
- After `rst` falls: first edge → RUN, `o_valid`=1; second edge → first possible advance.
- `i_halt` → `o_halted`=1 after 1 edge. `i_resume` → `o_valid`=1 after 1 edge.

## Configuration
- `PC_CALL_EN` defined:
  - Adds ports `i_call` (in, 1) and `i_ret` (in, 1), plus a one-entry return register.
  - In RUN with `i_en`, `i_call` behaves as a jump to `i_jmp_addr` and saves `o_pc`+1 in the return register.
  - `i_ret` loads `o_pc` from the return register.
  - Priority: halt > ret > call > jmp > increment.
  - `o_next_pc` and `o_jmp_sel` reflect call and ret (`o_jmp_sel`=1 for both).
  - A second call overwrites the return register; there is no stack.
- `PC_CALL_EN` not defined: the ports and register are absent, and behaviour is exactly as described above.

## Test plan
- Reset release with ADDR_W=4 and RESET_ADDR=0: `o_valid`=0 for 1 cycle, then 1. With `i_en`=1 held, `o_pc` goes 0,1,2,… one step per edge.
- Wrap: `o_pc`=15, `i_en`=1 → `o_pc`=0 and `o_wrap`=1 for one cycle. A jump 15→0 gives `o_wrap`=0.
- Jump: `o_pc`=3, `i_jmp`=1, `i_jmp_addr`=9, `i_en`=1 → same cycle `o_next_pc`=9 and `o_jmp_sel`=1; next cycle `o_pc`=9.
- Halt/resume:
  - `i_halt` together with `i_jmp` at `o_pc`=5 → `o_pc` stays 5, `o_halted`=1, `o_valid`=0.
  - `i_jmp` while halted is ignored.
  - `i_halt` and `i_resume` together in HALT → RUN. The next `i_en` gives 6.
- Async reset mid-run: assert `rst` between edges at `o_pc`=7 → `o_pc`=0 and `o_valid`=0 immediately, without waiting for an edge.
- With `PC_CALL_EN`: call at `o_pc`=2 to 10, advance to 11, then `i_ret` → `o_pc`=3.
